// File: rtl/rdma_meta_tx_arbiter_wrr.sv
// WRR arbiter for RDMA TX request metadata plus an in-order write-payload mux; grant is
// zero-latency, payload is passed through with a 1-cycle bubble only after IDLE; downstream stalls propagate straight to the owning source.
module rdma_meta_tx_arbiter_wrr #(
    parameter int N_CH      = 4,
    parameter int CH_BITS   = (N_CH > 1) ? $clog2(N_CH) : 1,
    parameter int DATA_BITS = 512,
    parameter int META_BITS = 128,
    parameter int LEN_BITS  = 28,
    parameter int W_BITS    = 4,
    parameter int SEQ_DEPTH = 16
) (
    input  logic                              aclk,
    input  logic                              aresetn,
    input  logic [N_CH*W_BITS-1:0]            cfg_weight,
    input  logic [N_CH-1:0]                   s_meta_valid,
    output logic [N_CH-1:0]                   s_meta_ready,
    input  logic [N_CH*META_BITS-1:0]         s_meta_data,
    input  logic [N_CH*LEN_BITS-1:0]          s_meta_len,
    input  logic [N_CH-1:0]                   s_meta_rd,
    output logic                              m_meta_valid,
    input  logic                              m_meta_ready,
    output logic [META_BITS-1:0]              m_meta_data,
    output logic [CH_BITS-1:0]                m_meta_vfid,
    input  logic [N_CH-1:0]                   s_axis_tvalid,
    output logic [N_CH-1:0]                   s_axis_tready,
    input  logic [N_CH-1:0]                   s_axis_tlast,
    input  logic [N_CH*DATA_BITS-1:0]         s_axis_tdata,
    input  logic [N_CH*(DATA_BITS/8)-1:0]     s_axis_tkeep,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    output logic                              m_axis_tlast,
    output logic [DATA_BITS-1:0]              m_axis_tdata,
    output logic [DATA_BITS/8-1:0]            m_axis_tkeep,
    output logic                              err_len,
    output logic [$clog2(SEQ_DEPTH):0]        seq_count
);
    localparam int BEAT_BYTES = DATA_BITS / 8;
    localparam int BB_SHIFT   = $clog2(BEAT_BYTES);
    localparam int Q_BITS     = (SEQ_DEPTH > 1) ? $clog2(SEQ_DEPTH) : 1;
    localparam int C_BITS     = $clog2(SEQ_DEPTH) + 1;

    typedef enum logic {ST_IDLE, ST_MUX} state_t;

    logic [CH_BITS-1:0]  r_ptr;
    logic [W_BITS-1:0]   r_credit;
    state_t              r_state;
    logic [CH_BITS-1:0]  r_vf;
    logic [LEN_BITS-1:0] r_cnt;
    logic                r_err;
    logic [C_BITS-1:0]   r_count;
    logic [Q_BITS-1:0]   r_wp;
    logic [Q_BITS-1:0]   r_rp;
    logic [CH_BITS-1:0]  r_q_vf  [SEQ_DEPTH];
    logic [LEN_BITS-1:0] r_q_cnt [SEQ_DEPTH];

    logic                w_pick_vld;
    logic [CH_BITS-1:0]  w_pick;
    logic [CH_BITS-1:0]  w_idx;
    logic [W_BITS-1:0]   w_wgt_pick;
    logic [W_BITS:0]     w_credit_inc;
    logic                w_rd;
    logic                w_q_full;
    logic                w_grant_ok;
    logic                w_hs;
    logic                w_push;
    logic [LEN_BITS-1:0] w_len;
    logic [LEN_BITS-1:0] w_push_cnt;
    logic                w_mux;
    logic                w_last;
    logic                w_beat;
    logic                w_pop;

    function automatic logic [CH_BITS-1:0] f_next(input logic [CH_BITS-1:0] c);
        f_next = (int'(c) == N_CH - 1) ? '0 : c + 1'b1;
    endfunction

    // First eligible channel scanning upward from the WRR pointer.
    always_comb begin
        w_pick_vld = 1'b0;
        w_pick     = '0;
        w_idx      = '0;
        for (int k = 0; k < N_CH; k++) begin
            w_idx = CH_BITS'((int'(r_ptr) + k) % N_CH);
            if (!w_pick_vld && s_meta_valid[w_idx] &&
                (cfg_weight[w_idx*W_BITS +: W_BITS] != '0)) begin
                w_pick_vld = 1'b1;
                w_pick     = w_idx;
            end
        end
    end

    assign w_wgt_pick   = cfg_weight[w_pick*W_BITS +: W_BITS];
    assign w_credit_inc = {1'b0, r_credit} + 1'b1;
    assign w_rd         = s_meta_rd[w_pick];
    assign w_q_full     = (r_count == C_BITS'(SEQ_DEPTH));
    assign w_grant_ok   = w_pick_vld & (w_rd | ~w_q_full);
    assign w_hs         = w_grant_ok & m_meta_ready;
    assign w_push       = w_hs & ~w_rd;
    assign w_len        = s_meta_len[w_pick*LEN_BITS +: LEN_BITS];
    // Stored as beats-1 so the data path can use cnt==0 as its last-beat flag.
    assign w_push_cnt   = (w_len == '0) ? '0 : ((w_len - LEN_BITS'(1)) >> BB_SHIFT);

    assign m_meta_valid = w_grant_ok;
    assign m_meta_data  = s_meta_data[w_pick*META_BITS +: META_BITS];
    assign m_meta_vfid  = w_pick;

    always_comb begin
        s_meta_ready = '0;
        if (w_hs) s_meta_ready[w_pick] = 1'b1;
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_ptr    <= '0;
            r_credit <= '0;
        end else if (w_hs) begin
            if (w_pick == r_ptr) begin
                if (w_credit_inc >= {1'b0, w_wgt_pick}) begin
                    r_ptr    <= f_next(r_ptr);
                    r_credit <= '0;
                end else begin
                    r_credit <= w_credit_inc[W_BITS-1:0];
                end
            end else if (w_wgt_pick == W_BITS'(1)) begin
                r_ptr    <= f_next(w_pick);
                r_credit <= '0;
            end else begin
                // Pointer owner was idle or masked: the picked channel inherits the turn.
                r_ptr    <= w_pick;
                r_credit <= W_BITS'(1);
            end
        end
    end

    assign w_mux  = (r_state == ST_MUX);
    assign w_last = (r_cnt == '0);
    assign w_beat = w_mux & s_axis_tvalid[r_vf] & m_axis_tready;
    assign w_pop  = (r_count != '0) & (~w_mux | (w_beat & w_last));

    always_ff @(posedge aclk) begin
        if (w_push) begin
            r_q_vf[r_wp]  <= w_pick;
            r_q_cnt[r_wp] <= w_push_cnt;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop)  r_rp <= r_rp + 1'b1;
            r_count <= r_count + C_BITS'(w_push) - C_BITS'(w_pop);
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state <= ST_IDLE;
            r_vf    <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_beat && (s_axis_tlast[r_vf] != w_last)) r_err <= 1'b1;
            if (w_pop) begin
                r_state <= ST_MUX;
                r_vf    <= r_q_vf[r_rp];
                r_cnt   <= r_q_cnt[r_rp];
            end else if (w_beat) begin
                if (w_last) r_state <= ST_IDLE;
                else        r_cnt   <= r_cnt - 1'b1;
            end
        end
    end

    assign m_axis_tvalid = w_mux & s_axis_tvalid[r_vf];
    assign m_axis_tlast  = w_mux & w_last;
    assign m_axis_tdata  = s_axis_tdata[r_vf*DATA_BITS +: DATA_BITS];
    assign m_axis_tkeep  = s_axis_tkeep[r_vf*BEAT_BYTES +: BEAT_BYTES];

    always_comb begin
        s_axis_tready = '0;
        if (w_mux) s_axis_tready[r_vf] = m_axis_tready;
    end

    assign err_len   = r_err;
    assign seq_count = r_count;

endmodule

// File: tb/tb_rdma_meta_tx_arbiter_wrr.sv
// Bench for rdma_meta_tx_arbiter_wrr: directed scenarios plus random traffic against a queue-based model.
module tb_rdma_meta_tx_arbiter_wrr;
    localparam int N = 4, DB = 512, MB = 128, LB = 28, WB = 4, SD = 16, BB = 64, CB = 2;

    logic              aclk = 1'b0;
    logic              aresetn;
    logic [N*WB-1:0]   cfg_weight;
    logic [N-1:0]      s_meta_valid, s_meta_ready, s_meta_rd;
    logic [N*MB-1:0]   s_meta_data;
    logic [N*LB-1:0]   s_meta_len;
    logic              m_meta_valid, m_meta_ready;
    logic [MB-1:0]     m_meta_data;
    logic [CB-1:0]     m_meta_vfid;
    logic [N-1:0]      s_axis_tvalid, s_axis_tready, s_axis_tlast;
    logic [N*DB-1:0]   s_axis_tdata;
    logic [N*BB-1:0]   s_axis_tkeep;
    logic              m_axis_tvalid, m_axis_tready, m_axis_tlast;
    logic [DB-1:0]     m_axis_tdata;
    logic [BB-1:0]     m_axis_tkeep;
    logic              err_len;
    logic [4:0]        seq_count;

    rdma_meta_tx_arbiter_wrr dut (
        .aclk(aclk), .aresetn(aresetn), .cfg_weight(cfg_weight),
        .s_meta_valid(s_meta_valid), .s_meta_ready(s_meta_ready), .s_meta_data(s_meta_data),
        .s_meta_len(s_meta_len), .s_meta_rd(s_meta_rd),
        .m_meta_valid(m_meta_valid), .m_meta_ready(m_meta_ready), .m_meta_data(m_meta_data),
        .m_meta_vfid(m_meta_vfid),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
        .err_len(err_len), .seq_count(seq_count)
    );

    always #5 aclk = ~aclk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input bit ok, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_eq(input string nm, input logic [63:0] act, input logic [63:0] exp);
        chk(nm, act === exp, act, exp);
    endtask

    // Reference model: WRR owner/used-grants, FIFO of pending writes (remaining beats after the first),
    // and the write currently being forwarded.
    int mp, mc;
    int qv[$];
    int qc[$];
    bit m_act, m_err;
    int m_vf, m_cnt;
    int pk, len_pk;
    bit ok, hs, ne;
    logic [63:0] exp_rdy;

    function automatic int wgt(input int i);
        return int'(cfg_weight[i*WB +: WB]);
    endfunction

    always @(negedge aclk) begin
        if (!aresetn) begin
            mp = 0; mc = 0; qv.delete(); qc.delete();
            m_act = 0; m_err = 0; m_vf = 0; m_cnt = 0;
        end else begin
            pk = -1;
            for (int k = 0; k < N; k++)
                if (pk < 0 && s_meta_valid[(mp + k) % N] && wgt((mp + k) % N) != 0) pk = (mp + k) % N;
            ok = (pk >= 0) && (s_meta_rd[pk] || qv.size() < SD);
            exp_rdy = (ok && m_meta_ready) ? (64'd1 << pk) : 64'd0;
            chk_eq("m_meta_valid", m_meta_valid, ok);
            chk_eq("s_meta_ready", s_meta_ready, exp_rdy);
            if (ok) begin
                chk_eq("m_meta_vfid", m_meta_vfid, pk);
                chk("m_meta_data", m_meta_data === s_meta_data[pk*MB +: MB], m_meta_data[63:0], s_meta_data[pk*MB +: 64]);
            end
            chk_eq("seq_count", seq_count, qv.size());
            chk_eq("err_len", err_len, m_err);
            if (m_act) begin
                chk_eq("m_axis_tvalid", m_axis_tvalid, s_axis_tvalid[m_vf]);
                chk_eq("m_axis_tlast", m_axis_tlast, m_cnt == 0);
                chk_eq("s_axis_tready", s_axis_tready, m_axis_tready ? (64'd1 << m_vf) : 64'd0);
                if (s_axis_tvalid[m_vf]) begin
                    chk("m_axis_tdata", m_axis_tdata === s_axis_tdata[m_vf*DB +: DB], m_axis_tdata[63:0], s_axis_tdata[m_vf*DB +: 64]);
                    chk("m_axis_tkeep", m_axis_tkeep === s_axis_tkeep[m_vf*BB +: BB], m_axis_tkeep, s_axis_tkeep[m_vf*BB +: BB]);
                end
            end else begin
                chk_eq("m_axis_tvalid_idle", m_axis_tvalid, 0);
                chk_eq("s_axis_tready_idle", s_axis_tready, 0);
            end

            hs = ok && m_meta_ready;
            ne = qv.size() != 0;
            if (hs) begin
                if (pk == mp) begin
                    mc++;
                    if (mc >= wgt(mp)) begin mp = (mp + 1) % N; mc = 0; end
                end else if (wgt(pk) == 1) begin
                    mp = (pk + 1) % N; mc = 0;
                end else begin
                    mp = pk; mc = 1;
                end
            end
            if (m_act) begin
                if (s_axis_tvalid[m_vf] && m_axis_tready) begin
                    if (s_axis_tlast[m_vf] != (m_cnt == 0)) m_err = 1;
                    if (m_cnt == 0) begin
                        if (ne) begin m_vf = qv.pop_front(); m_cnt = qc.pop_front(); end
                        else m_act = 0;
                    end else m_cnt--;
                end
            end else if (ne) begin
                m_act = 1; m_vf = qv.pop_front(); m_cnt = qc.pop_front();
            end
            if (hs && !s_meta_rd[pk]) begin
                len_pk = int'(s_meta_len[pk*LB +: LB]);
                qv.push_back(pk);
                qc.push_back(len_pk == 0 ? 0 : (len_pk + BB - 1) / BB - 1);
            end
        end
    end

    bit bad_tlast = 0;

    // Advance one cycle; payload is refreshed and source tlast follows the model's idea of the last beat.
    task automatic step();
        @(posedge aclk);
        #1;
        for (int w = 0; w < N*DB/32; w++) s_axis_tdata[w*32 +: 32] = $urandom;
        for (int w = 0; w < N*BB/32; w++) s_axis_tkeep[w*32 +: 32] = $urandom;
        s_axis_tlast = '0;
        if (m_act && m_cnt == 0) s_axis_tlast[m_vf] = 1'b1;
        if (bad_tlast) s_axis_tlast = ~s_axis_tlast;
    endtask

    task automatic set_len(input int ch, input int len);
        s_meta_len[ch*LB +: LB] = LB'(len);
    endtask

    int exp_rr [8]  = '{0, 1, 2, 3, 0, 1, 2, 3};
    int exp_wrr[10] = '{0, 0, 0, 1, 3, 3, 0, 0, 0, 1};
    bit exp_tv[6]   = '{0, 1, 1, 1, 1, 0};
    bit exp_tl[6]   = '{0, 0, 0, 1, 1, 0};
    int exp_sc[6]   = '{1, 1, 1, 1, 0, 0};
    int t, beats;

    initial begin
        aresetn = 0; cfg_weight = '0; s_meta_valid = '0; s_meta_rd = '0; s_meta_len = '0;
        m_meta_ready = 0; s_axis_tvalid = '0; s_axis_tlast = '0; m_axis_tready = 0;
        s_axis_tdata = '0; s_axis_tkeep = '0;
        for (int w = 0; w < N*MB/32; w++) s_meta_data[w*32 +: 32] = $urandom;
        repeat (2) step();
        aresetn = 1;
        #1;
        chk_eq("rst_m_meta_valid", m_meta_valid, 0);
        chk_eq("rst_seq_count", seq_count, 0);
        chk_eq("rst_err_len", err_len, 0);
        chk_eq("rst_m_axis_tvalid", m_axis_tvalid, 0);
        chk_eq("rst_s_axis_tready", s_axis_tready, 0);

        // Equal weights, all channels reading.
        cfg_weight = 16'h1111; s_meta_valid = 4'hf; s_meta_rd = 4'hf; m_meta_ready = 1;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk_eq("rr_seq", m_meta_vfid, exp_rr[i]);
            step();
        end

        // Weights {3,1,0,2} from a fresh pointer.
        aresetn = 0; s_meta_valid = '0;
        step();
        aresetn = 1; cfg_weight = {4'd2, 4'd0, 4'd1, 4'd3}; s_meta_valid = 4'hf;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk_eq("wrr_seq", m_meta_vfid, exp_wrr[i]);
            if (i < 9) step();
        end

        // Two back-to-back writes on channel 1: 130 bytes (3 beats) then 64 bytes (1 beat).
        cfg_weight = 16'h1111; s_meta_rd = '0; s_meta_valid = 4'b0010; set_len(1, 130);
        s_axis_tvalid = 4'hf; m_axis_tready = 1;
        #1;
        chk_eq("wr1_grant", {m_meta_valid, m_meta_vfid}, {1'b1, 2'd1});
        step();
        set_len(1, 64);
        for (int j = 0; j < 6; j++) begin
            if (j == 1) s_meta_valid = '0;
            #1;
            chk_eq("wr_tvalid", m_axis_tvalid, exp_tv[j]);
            if (exp_tv[j]) begin
                chk_eq("wr_tlast", m_axis_tlast, exp_tl[j]);
                chk_eq("wr_tready", s_axis_tready, 4'b0010);
            end
            chk_eq("wr_seq_count", seq_count, exp_sc[j]);
            step();
        end

        // Fill the write queue with the data path stalled; a read must still get through.
        m_axis_tready = 0; s_meta_valid = 4'b0001; s_meta_rd = '0; set_len(0, 64);
        t = 0;
        do begin step(); #1; t++; end while (!(seq_count == 5'd16 && !s_meta_ready[0]) && t < 60);
        chk_eq("full_seq_count", seq_count, 16);
        chk_eq("full_wr_blocked", {m_meta_valid, s_meta_ready}, 5'b0);
        s_meta_valid = 4'b0011; s_meta_rd = 4'b0010;
        #1;
        chk_eq("full_rd_grant", {m_meta_valid, m_meta_vfid, s_meta_ready}, {1'b1, 2'd1, 4'b0010});
        step();
        s_meta_valid = '0; m_axis_tready = 1;
        repeat (40) step();
        #1;
        chk_eq("drain_seq_count", seq_count, 0);

        // Zero-length write is a single last beat.
        s_meta_valid = 4'b1000; s_meta_rd = '0; set_len(3, 0);
        step();
        s_meta_valid = '0;
        #1;
        t = 0;
        while (!m_axis_tvalid && t < 10) begin step(); #1; t++; end
        chk_eq("len0_tvalid", m_axis_tvalid, 1);
        chk_eq("len0_tlast", m_axis_tlast, 1);
        step(); #1;
        chk_eq("len0_done", m_axis_tvalid, 0);

        // Early source tlast on a 2-beat write.
        s_meta_valid = 4'b0100; set_len(2, 100);
        step();
        s_meta_valid = '0;
        #1;
        t = 0;
        while (!m_axis_tvalid && t < 10) begin step(); #1; t++; end
        s_axis_tlast[2] = 1'b1;
        #1;
        beats = (m_axis_tvalid && m_axis_tready) ? 1 : 0;
        step(); #1;
        chk_eq("err_len_set", err_len, 1);
        chk_eq("err_beat2_tlast", {m_axis_tvalid, m_axis_tlast}, 2'b11);
        if (m_axis_tvalid && m_axis_tready) beats++;
        step(); #1;
        chk_eq("err_done", m_axis_tvalid, 0);
        chk_eq("err_beats", beats, 2);

        // Reset during beat 2 of a 4-beat write.
        s_meta_valid = 4'b0001; set_len(0, 256);
        step();
        s_meta_valid = '0;
        #1;
        t = 0;
        while (!m_axis_tvalid && t < 10) begin step(); #1; t++; end
        step(); #1;
        chk_eq("mid_beat2", {m_axis_tvalid, m_axis_tlast}, 2'b10);
        aresetn = 0;
        step();
        aresetn = 1;
        #1;
        chk_eq("mid_rst_seq_count", seq_count, 0);
        chk_eq("mid_rst_tvalid", m_axis_tvalid, 0);
        chk_eq("mid_rst_err_len", err_len, 0);
        s_meta_valid = 4'hf; s_meta_rd = 4'hf;
        #1;
        chk_eq("mid_rst_ptr", {m_meta_valid, m_meta_vfid}, {1'b1, 2'd0});
        step();
        s_meta_valid = '0;

        // Random traffic with occasional weight changes.
        for (int c = 0; c < 2000; c++) begin
            step();
            if ($urandom_range(0, 63) == 0)
                for (int i = 0; i < N; i++) cfg_weight[i*WB +: WB] = WB'($urandom_range(0, 3));
            s_meta_valid = N'($urandom);
            s_meta_rd = N'($urandom);
            for (int i = 0; i < N; i++) set_len(i, $urandom_range(0, 300));
            for (int w = 0; w < N*MB/32; w++) s_meta_data[w*32 +: 32] = $urandom;
            m_meta_ready = ($urandom_range(0, 3) != 0);
            s_axis_tvalid = N'($urandom);
            m_axis_tready = ($urandom_range(0, 3) != 0);
        end
        step();
        s_meta_valid = '0; s_axis_tvalid = '1; m_axis_tready = 1;
        repeat (200) step();
        #1;
        chk_eq("final_seq_count", seq_count, 0);
        chk_eq("final_tvalid", m_axis_tvalid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
